// File: rtl/math_pkg.sv
// ----------------------------------------------------------------------------
// math_pkg
// Shared constants and helpers for the squaring datapath.
//
// Contents:
//   SAMPLE_W  - ADC sample width (signed two's complement)
//   SQ_W      - width of the registered square
//   CODE_MSB  - top bit of the square that lands in the DAC code
//   CODE_LSB  - bottom bit of the square that lands in the DAC code
//   DAC_W     - width of the unsigned DAC code
//   code()    - reduces a square to a DAC code
//
// Build option:
//   MATH_SQ_ROUND_EN - when defined, code() rounds half up using the bit just
//                      below CODE_LSB; otherwise it truncates.
// ----------------------------------------------------------------------------
package math_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SQ_W     = 32;
    localparam int CODE_MSB = 30;
    localparam int CODE_LSB = 19;
    localparam int DAC_W    = CODE_MSB - CODE_LSB + 1;

    // A square of a 16-bit signed value never exceeds 2^30, so bit 31 is
    // always zero and the shifted value fits DAC_W bits exactly.  With
    // rounding the largest result is 0x800, which still fits, so no
    // saturation is needed.
    function automatic logic [DAC_W-1:0] code(input logic [SQ_W-1:0] sq);
`ifdef MATH_SQ_ROUND_EN
        code = DAC_W'(sq >> CODE_LSB) + DAC_W'(sq[CODE_LSB-1]);
`else
        code = DAC_W'(sq >> CODE_LSB);
`endif
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.  The search for a winner starts
// at the channel just after the most recently accepted one and wraps.
//
// Ports:
//   req   [N-1:0]  - request vector
//   last  [LW-1:0] - index of the most recently accepted channel
//   grant [N-1:0]  - one-hot grant, zero when nothing requests
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant
);

    logic [N-1:0]   upper_mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_pick;

    // Channels strictly above 'last' get first chance at the grant.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (i > int'(last));
        end
    end

    // Lower half holds the masked requests and upper half the full vector.
    // Isolating the lowest set bit of the doubled vector picks the first
    // requester above 'last' or, if there is none, wraps to the lowest
    // requester overall.  At most one half contributes a bit.
    assign dbl      = {req, req & upper_mask};
    assign dbl_pick = dbl & (-dbl);
    assign grant    = dbl_pick[N-1:0] | dbl_pick[2*N-1:N];

endmodule

// File: rtl/math_square_scheduler.sv
// ----------------------------------------------------------------------------
// math_square_scheduler
// Round-robin scheduler time-sharing one signed squaring datapath between
// NUM_CH ADC sample streams.  The granted sample is squared into stage 1;
// stage 2 reduces it to a 12-bit unsigned DAC code and presents it on a
// tagged valid/ready stream.
//
// Parameters:
//   NUM_CH - number of requesting channels (2..8)
//   CH_W   - channel tag width
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   ch_mask  - per-channel enable; masked channels are never granted
//   s_valid  - per-channel sample valid
//   s_data   - channel i sample at [16*i+15:16*i], signed
//   s_ready  - per-channel accept, at most one bit high
//   m_valid  - output code valid
//   m_data   - unsigned DAC code
//   m_ch     - channel that produced m_data
//   m_ready  - downstream accept
//   busy     - any pipeline stage holds a sample
//
// Build option:
//   MATH_SQ_ROUND_EN - selects round-half-up instead of truncation in the
//                      DAC code (see math_pkg::code); latency is unchanged.
// ----------------------------------------------------------------------------
module math_square_scheduler
    import math_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [NUM_CH-1:0]          s_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
    output logic [NUM_CH-1:0]          s_ready,
    output logic                       m_valid,
    output logic [DAC_W-1:0]           m_data,
    output logic [CH_W-1:0]            m_ch,
    input  logic                       m_ready,
    output logic                       busy
);

    logic [NUM_CH-1:0]          req;
    logic [NUM_CH-1:0]          grant;
    logic [CH_W-1:0]            last;
    logic [CH_W-1:0]            grant_idx;
    logic                       en;
    logic                       xfer;
    logic signed [SAMPLE_W-1:0] sample_sel;
    logic signed [SQ_W-1:0]     sample_ext;
    logic [SQ_W-1:0]            sq;
    logic [CH_W-1:0]            tag1;
    logic                       v1;

    assign req = s_valid & ch_mask;

    rr_arbiter #(
        .N  (NUM_CH),
        .LW (CH_W)
    ) u_arb (
        .req   (req),
        .last  (last),
        .grant (grant)
    );

    // The whole pipeline advances together whenever the output register is
    // empty or being drained; otherwise both stages freeze.
    assign en = !m_valid || m_ready;

    // s_ready is held low during reset even though the arbiter may already
    // see requests.
    assign s_ready = (rst || !en) ? '0 : grant;
    assign xfer    = |s_ready;
    assign busy    = v1 | m_valid;

    // Steer the granted channel's sample and index toward stage 1.
    always_comb begin
        sample_sel = '0;
        grant_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sample_sel = s_data[SAMPLE_W*i +: SAMPLE_W];
                grant_idx  = CH_W'(i);
            end
        end
    end

    // Explicit sign extension keeps the product a full 32-bit signed square.
    assign sample_ext = {{(SQ_W-SAMPLE_W){sample_sel[SAMPLE_W-1]}}, sample_sel};

    // Stage 1: the registered multiplier.  'last' only moves on a real
    // transfer so an idle cycle never disturbs the rotation.  Reset leaves
    // 'last' on the top channel so that channel 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            sq   <= '0;
            tag1 <= '0;
            last <= CH_W'(NUM_CH-1);
        end else if (en) begin
            v1 <= xfer;
            if (xfer) begin
                sq   <= sample_ext * sample_ext;
                tag1 <= grant_idx;
                last <= grant_idx;
            end
        end
    end

    // Stage 2: the output register.  Holding it while stalled keeps
    // m_data/m_ch stable for the downstream consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
        end else if (en) begin
            m_valid <= v1;
            m_data  <= code(sq);
            m_ch    <= tag1;
        end
    end

endmodule

// File: tb/tb_math_square_scheduler.sv
// ----------------------------------------------------------------------------
// tb_math_square_scheduler
// Self-checking bench for math_square_scheduler (NUM_CH = 4).  Directed
// vectors with hand-computed codes, plus a cycle-level reference of the
// scheduler that every stepped cycle is compared against.
// ----------------------------------------------------------------------------
module tb_math_square_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_mask;
    logic [3:0]  s_valid;
    logic [63:0] s_data;
    logic [3:0]  s_ready;
    logic        m_valid;
    logic [11:0] m_data;
    logic [1:0]  m_ch;
    logic        m_ready;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    // Reference state: last accepted channel, stage 1 and output stage.
    int   mLast;
    logic mV1;
    int   mTag1;
    int   mCode1;
    logic mMv;
    int   mCh;
    int   mCode;

    logic [15:0] codeIn  [5];
    logic [11:0] codeExp [5];
    int          fairSeq [6];
    int          xferCount;

    always #5 clk = ~clk;

    math_square_scheduler #(
        .NUM_CH (4),
        .CH_W   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_mask (ch_mask),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ch    (m_ch),
        .m_ready (m_ready),
        .busy    (busy)
    );

    // Counts one comparison and reports it when it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      tag, observed, expected, $time);
    endtask

    // Square and scale by 2^-19, optionally rounding half up.
    function automatic int modelCode(input logic signed [15:0] x);
        longint p;
        p = longint'(x) * longint'(x);
`ifdef MATH_SQ_ROUND_EN
        return int'((p + 262144) / 524288);
`else
        return int'(p / 524288);
`endif
    endfunction

    // Circular search for the first requester after 'last'.
    function automatic logic [3:0] modelGrant(input logic [3:0] v, input logic [3:0] m,
                                              input int last, input logic en);
        logic [3:0] r;
        logic       found;
        r     = v & m;
        found = 1'b0;
        modelGrant = '0;
        if (en) begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (last + k) % 4;
                if (!found && r[idx]) begin
                    modelGrant[idx] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    endfunction

    task automatic modelReset();
        mLast  = 3;
        mV1    = 1'b0;
        mTag1  = 0;
        mCode1 = 0;
        mMv    = 1'b0;
        mCh    = 0;
        mCode  = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] mask,
                                 input logic ready);
        s_valid = valid;
        ch_mask = mask;
        m_ready = ready;
    endtask

    task automatic setSample(input int ch, input logic [15:0] val);
        s_data[16*ch +: 16] = val;
    endtask

    // Advances one clock, checking s_ready before the edge and the outputs
    // just after it against the reference.  Ends 1 time unit after the edge.
    task automatic stepCycle();
        logic       en;
        logic [3:0] g;
        #1;
        en = !mMv || m_ready;
        g  = modelGrant(s_valid, ch_mask, mLast, en);
        checkOutput("s_ready", s_ready, g);
        checkOutput("s_ready_onehot", $countones(s_ready) <= 1, 1);
        @(posedge clk);
        if (en) begin
            mMv   = mV1;
            mCh   = mTag1;
            mCode = mCode1;
            mV1   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    mV1    = 1'b1;
                    mTag1  = i;
                    mCode1 = modelCode(s_data[16*i +: 16]);
                    mLast  = i;
                end
            end
        end
        #1;
        checkOutput("m_valid", m_valid, mMv);
        checkOutput("busy", busy, mMv | mV1);
        if (mMv) begin
            checkOutput("m_data", m_data, mCode);
            checkOutput("m_ch", m_ch, mCh);
        end
    endtask

    task automatic doReset();
        #2;
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        codeIn[0] = 16'hC000; codeExp[0] = 12'h200;
        codeIn[1] = 16'h7FFF;
`ifdef MATH_SQ_ROUND_EN
        codeExp[1] = 12'h800;
`else
        codeExp[1] = 12'h7FF;
`endif
        codeIn[2] = 16'd1000;
`ifdef MATH_SQ_ROUND_EN
        codeExp[2] = 12'd2;
`else
        codeExp[2] = 12'd1;
`endif
        codeIn[3] = 16'h0000; codeExp[3] = 12'h000;
        codeIn[4] = 16'h8000; codeExp[4] = 12'h800;
        fairSeq[0] = 0; fairSeq[1] = 1; fairSeq[2] = 3;
        fairSeq[3] = 0; fairSeq[4] = 1; fairSeq[5] = 3;

        // Reset values, with a request pending to prove s_ready is gated.
        rst    = 1'b1;
        s_data = '0;
        applyStimulus(4'b0001, 4'hF, 1'b1);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_m_ch", m_ch, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_s_ready", s_ready, 0);
        rst = 1'b0;

        // Single transfer on channel 0: 0x4000^2 >> 19 = 0x200.
        setSample(0, 16'h4000);
        #1;
        checkOutput("single_s_ready", s_ready, 4'b0001);
        stepCycle();
        applyStimulus(4'b0000, 4'hF, 1'b1);
        checkOutput("single_not_yet", m_valid, 0);
        stepCycle();
        checkOutput("single_m_valid", m_valid, 1);
        checkOutput("single_m_data", m_data, 12'h200);
        checkOutput("single_m_ch", m_ch, 0);

        // Back-to-back code values on channel 0.
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) begin
                applyStimulus(4'b0001, 4'hF, 1'b1);
                setSample(0, codeIn[k]);
            end else begin
                applyStimulus(4'b0000, 4'hF, 1'b1);
            end
            stepCycle();
            if (k >= 1) begin
                checkOutput($sformatf("code_valid_%0d", k - 1), m_valid, 1);
                checkOutput($sformatf("code_value_%0d", k - 1), m_data, codeExp[k - 1]);
            end
        end
        stepCycle();

        // Fairness: all four channels streaming give 0,1,2,3 with no gaps.
        doReset();
        setSample(0, 16'h4000);
        setSample(1, 16'h2000);
        setSample(2, 16'h1000);
        setSample(3, 16'h0800);
        applyStimulus(4'hF, 4'hF, 1'b1);
        for (int s = 1; s <= 18; s++) begin
            if (s == 17) applyStimulus(4'h0, 4'hF, 1'b1);
            stepCycle();
            if (s >= 2 && s <= 17) begin
                checkOutput($sformatf("fair_valid_%0d", s), m_valid, 1);
                checkOutput($sformatf("fair_ch_%0d", s), m_ch, (s - 2) % 4);
            end
        end

        // Channel 2 masked: rotation becomes 0,1,3.
        applyStimulus(4'hF, 4'b1011, 1'b1);
        for (int s = 1; s <= 8; s++) begin
            if (s == 7) applyStimulus(4'h0, 4'b1011, 1'b1);
            stepCycle();
            if (s >= 2 && s <= 7) begin
                checkOutput($sformatf("mask_ch_%0d", s), m_ch, fairSeq[s - 2]);
            end
        end

        // Backpressure: only two samples may enter while m_ready is low.
        doReset();
        applyStimulus(4'hF, 4'hF, 1'b0);
        xferCount = 0;
        for (int s = 1; s <= 10; s++) begin
            #1;
            xferCount += $countones(s_valid & s_ready);
            stepCycle();
            if (s >= 2) begin
                checkOutput("stall_m_valid", m_valid, 1);
                checkOutput("stall_m_ch", m_ch, 0);
                checkOutput("stall_m_data", m_data, 12'h200);
            end
        end
        checkOutput("stall_transfers", xferCount, 2);
        applyStimulus(4'hF, 4'hF, 1'b1);
        for (int s = 1; s <= 3; s++) begin
            stepCycle();
            checkOutput($sformatf("release_ch_%0d", s), m_ch, s);
        end

        // Asynchronous reset between edges while streaming.
        #4;
        rst = 1'b1;
        #1;
        checkOutput("async_m_valid", m_valid, 0);
        checkOutput("async_s_ready", s_ready, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_m_data", m_data, 0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_first_grant", s_ready, 4'b0001);
        for (int s = 0; s < 4; s++) stepCycle();

        // Random traffic against the reference.
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
            s_data = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) setSample($urandom_range(0, 3), 16'h8000);
            if ($urandom_range(0, 15) == 0) setSample($urandom_range(0, 3), 16'h7FFF);
            stepCycle();
        end
        applyStimulus(4'h0, 4'hF, 1'b1);
        for (int s = 0; s < 3; s++) stepCycle();
        checkOutput("drained_busy", busy, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
